// File: rtl/decode_stage.sv
// decode_stage
// ------------
// Single-entry RV32I decode stage between fetch and execute. An instruction
// is taken from the fetch valid/ready channel and decoded into immediate, ALU
// op and control flags. Register file operands are captured in the same cycle,
// and everything is presented on the execute channel one cycle later. While
// execute stalls, the held instruction keeps its operands current by snooping
// the register file write port.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   fetch_valid_i/fetch_ready_o   upstream handshake
//   fetch_pc_i, fetch_instruction_i
//   rs1_address_o, rs2_address_o  register file read addresses (combinational)
//   rs1_data_i, rs2_data_i        register file read data (already bypassed)
//   writeback_enable_i/address_i/data_i  snoop of the register file write port
//   flush_i                       drop held and incoming instruction
//   execute_valid_o/execute_ready_i      downstream handshake
//   execute_pc_o, execute_instruction_o, execute_rs1_data_o,
//   execute_rs2_data_o, execute_immediate_o, execute_rd_address_o,
//   execute_alu_op_o, execute_use_immediate_o, execute_write_enable_o,
//   execute_illegal_o             registered decode results
//
// Configuration
//   NEBULA_DECODE_ILLEGAL_CHECK_EN  when defined, flags words that are not one
//   of the eleven RV32I base opcodes (or lack the 2'b11 length bits) as illegal
//   and suppresses their register write. Otherwise execute_illegal_o is 0.

module decode_stage #(
  parameter logic [31:0] NopInstruction = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] fetch_instruction_i,
  output logic [4:0]  rs1_address_o,
  output logic [4:0]  rs2_address_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        writeback_enable_i,
  input  logic [4:0]  writeback_address_i,
  input  logic [31:0] writeback_data_i,
  input  logic        flush_i,
  output logic        execute_valid_o,
  input  logic        execute_ready_i,
  output logic [31:0] execute_pc_o,
  output logic [31:0] execute_instruction_o,
  output logic [31:0] execute_rs1_data_o,
  output logic [31:0] execute_rs2_data_o,
  output logic [31:0] execute_immediate_o,
  output logic [4:0]  execute_rd_address_o,
  output logic [3:0]  execute_alu_op_o,
  output logic        execute_use_immediate_o,
  output logic        execute_write_enable_o,
  output logic        execute_illegal_o
);

  localparam logic [6:0] OpcodeLui     = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc   = 7'b0010111;
  localparam logic [6:0] OpcodeJal     = 7'b1101111;
  localparam logic [6:0] OpcodeJalr    = 7'b1100111;
  localparam logic [6:0] OpcodeBranch  = 7'b1100011;
  localparam logic [6:0] OpcodeLoad    = 7'b0000011;
  localparam logic [6:0] OpcodeStore   = 7'b0100011;
  localparam logic [6:0] OpcodeOpImm   = 7'b0010011;
  localparam logic [6:0] OpcodeOp      = 7'b0110011;
  localparam logic [6:0] OpcodeMiscMem = 7'b0001111;
  localparam logic [6:0] OpcodeSystem  = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic        dec_known;
  logic        dec_write_class;
  logic [31:0] dec_immediate;
  logic [3:0]  dec_alu_op;
  logic        dec_use_immediate;
  logic        dec_write_enable;

  logic        accept;
  logic        hold;
  logic        snoop_rs1;
  logic        snoop_rs2;

  // Register file addresses come straight from the fetch word so the read
  // data is ready by the time the word is accepted.
  assign rs1_address_o = fetch_instruction_i[19:15];
  assign rs2_address_o = fetch_instruction_i[24:20];

  assign fetch_ready_o = !execute_valid_o || execute_ready_i;
  assign accept        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign hold          = execute_valid_o && !execute_ready_i;

  assign opcode = fetch_instruction_i[6:0];
  assign funct3 = fetch_instruction_i[14:12];
  assign rd     = fetch_instruction_i[11:7];

  assign imm_i = {{20{fetch_instruction_i[31]}}, fetch_instruction_i[31:20]};
  assign imm_s = {{20{fetch_instruction_i[31]}}, fetch_instruction_i[31:25],
                  fetch_instruction_i[11:7]};
  assign imm_b = {{19{fetch_instruction_i[31]}}, fetch_instruction_i[31],
                  fetch_instruction_i[7], fetch_instruction_i[30:25],
                  fetch_instruction_i[11:8], 1'b0};
  assign imm_u = {fetch_instruction_i[31:12], 12'b0};
  assign imm_j = {{11{fetch_instruction_i[31]}}, fetch_instruction_i[31],
                  fetch_instruction_i[19:12], fetch_instruction_i[20],
                  fetch_instruction_i[30:21], 1'b0};

  // Opcode classification and immediate selection for the incoming word.
  always_comb begin
    dec_known       = 1'b0;
    dec_write_class = 1'b0;
    dec_immediate   = 32'b0;
    unique case (opcode)
      OpcodeLui, OpcodeAuipc: begin
        dec_known       = 1'b1;
        dec_write_class = 1'b1;
        dec_immediate   = imm_u;
      end
      OpcodeJal: begin
        dec_known       = 1'b1;
        dec_write_class = 1'b1;
        dec_immediate   = imm_j;
      end
      OpcodeJalr, OpcodeLoad, OpcodeOpImm: begin
        dec_known       = 1'b1;
        dec_write_class = 1'b1;
        dec_immediate   = imm_i;
      end
      OpcodeStore: begin
        dec_known     = 1'b1;
        dec_immediate = imm_s;
      end
      OpcodeBranch: begin
        dec_known     = 1'b1;
        dec_immediate = imm_b;
      end
      OpcodeOp: begin
        dec_known       = 1'b1;
        dec_write_class = 1'b1;
      end
      OpcodeMiscMem, OpcodeSystem: begin
        dec_known = 1'b1;
      end
      default: begin
        dec_known = 1'b0;
      end
    endcase
  end

  // Bit 30 only selects SUB/SRA for register ops and for the right-shift
  // immediates; elsewhere it is immediate payload and must not leak in.
  assign dec_alu_op = (opcode == OpcodeOp || (opcode == OpcodeOpImm && funct3 == 3'b101))
                      ? {fetch_instruction_i[30], funct3}
                      : {1'b0, funct3};

  // Unknown opcodes keep every enable low.
  assign dec_use_immediate = dec_known && (opcode != OpcodeOp) && (opcode != OpcodeBranch);

`ifdef NEBULA_DECODE_ILLEGAL_CHECK_EN
  logic dec_illegal;
  assign dec_illegal      = (fetch_instruction_i[1:0] != 2'b11) || !dec_known;
  assign dec_write_enable = dec_write_class && (rd != 5'd0) && !dec_illegal;
`else
  assign dec_write_enable = dec_write_class && (rd != 5'd0);
`endif

  // Snoop matches use the register fields of the held word, so a stalled
  // instruction never executes with stale operands.
  assign snoop_rs1 = hold && writeback_enable_i && (writeback_address_i != 5'd0) &&
                     (writeback_address_i == execute_instruction_o[19:15]);
  assign snoop_rs2 = hold && writeback_enable_i && (writeback_address_i != 5'd0) &&
                     (writeback_address_i == execute_instruction_o[24:20]);

  // Output register. Priority: reset, flush, accept, stall with snoop, drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      execute_valid_o         <= 1'b0;
      execute_pc_o            <= 32'b0;
      execute_instruction_o   <= NopInstruction;
      execute_rs1_data_o      <= 32'b0;
      execute_rs2_data_o      <= 32'b0;
      execute_immediate_o     <= 32'b0;
      execute_rd_address_o    <= 5'b0;
      execute_alu_op_o        <= 4'b0;
      execute_use_immediate_o <= 1'b0;
      execute_write_enable_o  <= 1'b0;
    end else if (flush_i) begin
      execute_valid_o       <= 1'b0;
      execute_instruction_o <= NopInstruction;
    end else if (accept) begin
      execute_valid_o         <= 1'b1;
      execute_pc_o            <= fetch_pc_i;
      execute_instruction_o   <= fetch_instruction_i;
      execute_rs1_data_o      <= rs1_data_i;
      execute_rs2_data_o      <= rs2_data_i;
      execute_immediate_o     <= dec_immediate;
      execute_rd_address_o    <= rd;
      execute_alu_op_o        <= dec_alu_op;
      execute_use_immediate_o <= dec_use_immediate;
      execute_write_enable_o  <= dec_write_enable;
    end else if (hold) begin
      if (snoop_rs1) begin
        execute_rs1_data_o <= writeback_data_i;
      end
      if (snoop_rs2) begin
        execute_rs2_data_o <= writeback_data_i;
      end
    end else begin
      execute_valid_o <= 1'b0;
    end
  end

`ifdef NEBULA_DECODE_ILLEGAL_CHECK_EN
  // Illegal flag follows the same load/flush rules as the rest of the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      execute_illegal_o <= 1'b0;
    end else if (flush_i) begin
      execute_illegal_o <= 1'b0;
    end else if (accept) begin
      execute_illegal_o <= dec_illegal;
    end
  end
`else
  assign execute_illegal_o = 1'b0;
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter NopInstruction, default 32'h0000_0013, meaning the instruction word the output register holds after reset or flush.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports fetch_valid_i in 1, fetch_ready_o out 1, fetch_pc_i in 32 and fetch_instruction_i in 32, the upstream valid/ready instruction channel.
REQ-005 The block SHALL have ports rs1_address_o out 5 and rs2_address_o out 5, the register file read port 0/1 addresses.
REQ-006 The block SHALL have ports rs1_data_i in 32 and rs2_data_i in 32, the register file read data, already write-bypassed by the register file.
REQ-007 The block SHALL have ports writeback_enable_i in 1, writeback_address_i in 5 and writeback_data_i in 32, a snoop copy of the register file write port.
REQ-008 The block SHALL have port flush_i, input, 1, which discards the held and the incoming instruction.
REQ-009 The block SHALL have ports execute_valid_o out 1, execute_ready_i in 1, and execute_pc_o, execute_instruction_o, execute_rs1_data_o, execute_rs2_data_o and execute_immediate_o out 32 each.
REQ-010 The block SHALL have ports execute_rd_address_o out 5, execute_alu_op_o out 4, execute_use_immediate_o out 1, execute_write_enable_o out 1 and execute_illegal_o out 1.

Function
REQ-011 The block SHALL drive rs1_address_o and rs2_address_o combinationally from fetch_instruction_i[19:15] and [24:20] respectively, regardless of fetch_valid_i.
REQ-012 The block SHALL drive fetch_ready_o as !execute_valid_o || execute_ready_i, with no dependence on fetch_valid_i.
REQ-013 The block SHALL latch the fetch channel and the decode results when fetch_valid_i && fetch_ready_o && !flush_i, so the instruction appears at the output the following cycle (latency 1).
REQ-014 On a cycle with execute_valid_o && execute_ready_i and no accept, the block SHALL clear execute_valid_o next cycle.
REQ-015 While execute_valid_o && !execute_ready_i, the block SHALL hold every output stable, except for the writeback snoop update in REQ-016.
REQ-016 During a hold, a writeback with writeback_enable_i and a nonzero writeback_address_i that equals the held rs1 or rs2 field SHALL overwrite the matching held data with writeback_data_i; both operands SHALL be updated if both match.
REQ-017 The block SHALL generate the immediate per format, sign-extended from instruction bit 31: I for OP-IMM, LOAD and JALR; S for STORE; B for BRANCH; U for LUI and AUIPC; J for JAL; 0 otherwise.
REQ-018 The block SHALL form execute_alu_op_o as {instruction[30], funct3} for OP and for OP-IMM with funct3 = 101, and as {1'b0, funct3} for every other opcode.
REQ-019 The block SHALL set execute_use_immediate_o for every format except OP and BRANCH.
REQ-020 The block SHALL set execute_write_enable_o for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and SHALL force it to 0 when rd = x0.
REQ-021 When flush_i is high, execute_valid_o SHALL be 0 next cycle, no instruction SHALL be accepted, and the output instruction SHALL be reloaded with NopInstruction; flush takes priority over all other events.

Reset
REQ-022 While rst_i is asserted, the block SHALL clear execute_valid_o, execute_illegal_o and every data output to 0, and SHALL set execute_instruction_o to NopInstruction.
REQ-023 The first accept SHALL occur no earlier than the first rising clk_i edge after rst_i deasserts, and a reset asserted mid-hold SHALL drop the held instruction.

Configuration
REQ-024 With macro NEBULA_DECODE_ILLEGAL_CHECK_EN defined, execute_illegal_o SHALL be set for an accepted word whose bits [1:0] != 2'b11 or whose opcode lies outside the eleven RV32I base opcodes, and execute_write_enable_o SHALL then be forced to 0.
REQ-025 With NEBULA_DECODE_ILLEGAL_CHECK_EN undefined, execute_illegal_o SHALL be tied to 0 and unknown opcodes SHALL decode with every enable low.

Verification
REQ-026 Accept 0x00510093 (addi x1,x2,5) with rs2_data_i=7 -> next cycle rs1_address_o had been 2, execute_immediate_o=5, execute_rd_address_o=1, write enable 1, use-immediate 1.
REQ-027 Accept 0xFFC12083 (lw x1,-4(x2)) -> execute_immediate_o=0xFFFFFFFC, execute_alu_op_o=4'b0010.
REQ-028 Hold addi x1,x2,5 with execute_ready_i=0 and writeback x2=0xDEAD -> execute_rs1_data_o becomes 0xDEAD next cycle; a writeback to x0 changes nothing.
REQ-029 Assert flush_i while fetch_valid_i=1 and output valid -> next cycle execute_valid_o=0 and execute_instruction_o=0x00000013.
REQ-030 Accept 0x00000000 with the macro defined -> execute_illegal_o=1 and write enable 0; with the macro undefined -> execute_illegal_o=0.
REQ-031 Run back-to-back accepts with execute_ready_i=1 -> one instruction per cycle and fetch_ready_o constantly 1.
